// File: rtl/clk_edge_monitor_if.sv
// rtl/clk_edge_monitor_if.sv - slow-clock monitor control/status bundle
interface clk_edge_monitor_if #(
    parameter int NBITS = 13
);
    logic             i_enable;
    logic             i_clk_slow;
    logic             o_rise;
    logic             o_fall;
    logic [NBITS-1:0] o_period;
    logic             o_period_valid;
    logic             o_locked;
    logic             o_timeout;

    modport master (
        output i_enable, i_clk_slow,
        input  o_rise, o_fall, o_period, o_period_valid, o_locked, o_timeout
    );

    modport slave (
        input  i_enable, i_clk_slow,
        output o_rise, o_fall, o_period, o_period_valid, o_locked, o_timeout
    );
endinterface

// File: rtl/clk_edge_monitor.sv
// rtl/clk_edge_monitor.sv - slow clock edge strobes, period measurement and lock detect
// Optional 3-sample glitch filter: define CLK_EDGE_MONITOR_GLITCH_FILTER_EN.
module clk_edge_monitor #(
    parameter int F_CLK_IN    = 50_000_000,
    parameter int F_CLK_OUT   = 48_000,
    parameter int SYNC_STAGES = 2,
    parameter int LOCK_COUNT  = 4,
    parameter int TOL         = 2
) (
    input  logic              clk,
    input  logic              i_rst,
    clk_edge_monitor_if.slave mon
);
    localparam int EXP     = 2 * (F_CLK_IN / F_CLK_OUT);
    localparam int TIMEOUT = 2 * EXP;
    localparam int NBITS   = $clog2(TIMEOUT + 1);
    localparam int GBITS   = $clog2(LOCK_COUNT + 1);

    localparam logic [NBITS-1:0] LO_N         = NBITS'(EXP - TOL);
    localparam logic [NBITS-1:0] HI_N         = NBITS'(EXP + TOL);
    localparam logic [NBITS-1:0] TIMEOUT_N    = NBITS'(TIMEOUT);
    localparam logic [NBITS-1:0] TIMEOUT_M1_N = NBITS'(TIMEOUT - 1);
    localparam logic [GBITS-1:0] LOCK_N       = GBITS'(LOCK_COUNT);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_MEASURE = 2'd1;
    localparam logic [1:0] ST_LOCKED  = 2'd2;

    generate
        if (SYNC_STAGES < 2 || LOCK_COUNT < 1 || TOL >= EXP || EXP + TOL > TIMEOUT) begin : g_bad_params
            $error("clk_edge_monitor: illegal parameter combination");
        end
    endgenerate

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s_prev_q;
    logic                   s_sync;
    logic                   s;
    logic                   rise;
    logic                   fall;

    assign s_sync = sync_q[SYNC_STAGES-1];

`ifdef CLK_EDGE_MONITOR_GLITCH_FILTER_EN
    logic [1:0] filt_q;
    // Follow the synchronizer only once three consecutive samples agree.
    assign s = (s_sync == filt_q[0] && filt_q[0] == filt_q[1]) ? s_sync : s_prev_q;
`else
    assign s = s_sync;
`endif

    assign rise = s & ~s_prev_q;
    assign fall = ~s & s_prev_q;

    logic [1:0]       state_q, state_d;
    logic [NBITS-1:0] cnt_q, cnt_d;
    logic [GBITS-1:0] good_q, good_d;
    logic [NBITS-1:0] period_q, period_d;
    logic             valid_q, valid_d;
    logic             rise_q, rise_d;
    logic             fall_q, fall_d;
    logic             locked_q, locked_d;
    logic             timeout_q, timeout_d;
    logic [NBITS-1:0] meas;
    logic             in_tol;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        good_d    = good_q;
        period_d  = period_q;
        valid_d   = 1'b0;
        rise_d    = rise;
        fall_d    = fall;
        locked_d  = locked_q;
        timeout_d = timeout_q;
        meas      = cnt_q + 1'b1;
        in_tol    = (meas >= LO_N) && (meas <= HI_N);

        if (cnt_q != TIMEOUT_N) begin
            cnt_d = cnt_q + 1'b1;
        end

        // A rise wins over a timeout landing on the same cycle.
        if (rise) begin
            cnt_d     = '0;
            timeout_d = 1'b0;
            case (state_q)
                ST_IDLE: state_d = ST_MEASURE;
                ST_MEASURE: begin
                    period_d = meas;
                    valid_d  = 1'b1;
                    if (!in_tol) begin
                        good_d = '0;
                    end else if (good_q + 1'b1 == LOCK_N) begin
                        good_d   = '0;
                        state_d  = ST_LOCKED;
                        locked_d = 1'b1;
                    end else begin
                        good_d = good_q + 1'b1;
                    end
                end
                ST_LOCKED: begin
                    period_d = meas;
                    valid_d  = 1'b1;
                    if (!in_tol) begin
                        state_d  = ST_MEASURE;
                        locked_d = 1'b0;
                        good_d   = '0;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end else if (cnt_q == TIMEOUT_M1_N) begin
            timeout_d = 1'b1;
            locked_d  = 1'b0;
            good_d    = '0;
            state_d   = ST_IDLE;
        end

        if (!mon.i_enable) begin
            state_d   = ST_IDLE;
            cnt_d     = '0;
            good_d    = '0;
            period_d  = '0;
            valid_d   = 1'b0;
            rise_d    = 1'b0;
            fall_d    = 1'b0;
            locked_d  = 1'b0;
            timeout_d = 1'b0;
        end
    end

    // The synchronizer keeps sampling while disabled so re-enable sees no stale edge.
    always_ff @(posedge clk) begin
        if (i_rst) begin
            sync_q    <= '0;
            s_prev_q  <= 1'b0;
`ifdef CLK_EDGE_MONITOR_GLITCH_FILTER_EN
            filt_q    <= '0;
`endif
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            good_q    <= '0;
            period_q  <= '0;
            valid_q   <= 1'b0;
            rise_q    <= 1'b0;
            fall_q    <= 1'b0;
            locked_q  <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            sync_q    <= {sync_q[SYNC_STAGES-2:0], mon.i_clk_slow};
            s_prev_q  <= s;
`ifdef CLK_EDGE_MONITOR_GLITCH_FILTER_EN
            filt_q    <= {filt_q[0], s_sync};
`endif
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            good_q    <= good_d;
            period_q  <= period_d;
            valid_q   <= valid_d;
            rise_q    <= rise_d;
            fall_q    <= fall_d;
            locked_q  <= locked_d;
            timeout_q <= timeout_d;
        end
    end

    assign mon.o_rise         = rise_q;
    assign mon.o_fall         = fall_q;
    assign mon.o_period       = period_q;
    assign mon.o_period_valid = valid_q;
    assign mon.o_locked       = locked_q;
    assign mon.o_timeout      = timeout_q;
endmodule

// File: tb/tb_clk_edge_monitor.sv
// tb/tb_clk_edge_monitor.sv - scoreboard bench for clk_edge_monitor
module tb_clk_edge_monitor;
    localparam int NBITS   = 13;
    localparam int TIMEOUT = 4164;
`ifdef CLK_EDGE_MONITOR_GLITCH_FILTER_EN
    localparam int LAT = 5;
`else
    localparam int LAT = 3;
`endif

    typedef struct {
        bit is_rise;
        int due;
        bit ev;
        int period;
        bit el;
    } sb_t;

    logic clk = 1'b0;
    logic i_rst;
    int   cyc = 0;
    int   last_rise = 0;
    int   n_checks = 0;
    int   n_pass = 0;
    sb_t  sb[$];
    sb_t  mon_e;

    clk_edge_monitor_if #(.NBITS(NBITS)) bus ();

    clk_edge_monitor dut (
        .clk   (clk),
        .i_rst (i_rst),
        .mon   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard consumer: every strobe must match the oldest expected transition.
    always @(negedge clk) begin
        if (bus.o_period_valid === 1'b1 && bus.o_rise !== 1'b1) begin
            n_checks++;
            $display("FAIL valid_without_rise cyc=%0d", cyc);
        end
        if (bus.o_rise === 1'b1 || bus.o_fall === 1'b1) begin
            n_checks++;
            if (sb.size() == 0) begin
                $display("FAIL unexpected_edge cyc=%0d rise=%0b fall=%0b", cyc, bus.o_rise, bus.o_fall);
            end else begin
                mon_e = sb.pop_front();
                if (bus.o_rise !== mon_e.is_rise) $display("FAIL edge_kind cyc=%0d got_rise=%0b exp_rise=%0b", cyc, bus.o_rise, mon_e.is_rise);
                else n_pass++;
                n_checks++;
                if (cyc !== mon_e.due) $display("FAIL edge_latency got_cyc=%0d exp_cyc=%0d", cyc, mon_e.due);
                else n_pass++;
                if (mon_e.is_rise) begin
                    n_checks++;
                    if (bus.o_period_valid !== mon_e.ev) $display("FAIL period_valid cyc=%0d got=%0b exp=%0b", cyc, bus.o_period_valid, mon_e.ev);
                    else n_pass++;
                    n_checks++;
                    if (bus.o_locked !== mon_e.el) $display("FAIL locked_at_rise cyc=%0d got=%0b exp=%0b", cyc, bus.o_locked, mon_e.el);
                    else n_pass++;
                    if (mon_e.ev) begin
                        n_checks++;
                        if (bus.o_period !== NBITS'(mon_e.period)) $display("FAIL period cyc=%0d got=%0d exp=%0d", cyc, bus.o_period, mon_e.period);
                        else n_pass++;
                    end
                end
            end
        end else if (sb.size() > 0 && cyc > sb[0].due) begin
            n_checks++;
            $display("FAIL missing_edge got_cyc=%0d exp_cyc=%0d rise=%0b", cyc, sb[0].due, sb[0].is_rise);
            void'(sb.pop_front());
        end
    end

    task automatic set_slow(input logic v, input bit push, input bit ev, input bit el);
        sb_t e;
        @(negedge clk);
        bus.i_clk_slow = v;
        if (push) begin
            e.is_rise = v;
            e.due     = cyc + LAT;
            e.ev      = ev;
            e.el      = el;
            e.period  = cyc - last_rise;
            sb.push_back(e);
            if (v) last_rise = cyc;
        end
    endtask

    task automatic hold(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic period(input int hi, input int lo, input bit ev, input bit el);
        hold(hi - 1);
        set_slow(1'b0, 1'b1, 1'b0, 1'b0);
        hold(lo - 1);
        set_slow(1'b1, 1'b1, ev, el);
    endtask

    task automatic test_reset;
        i_rst = 1'b1;
        bus.i_enable = 1'b1;
        bus.i_clk_slow = 1'b0;
        hold(3);
        n_checks++; if (bus.o_rise !== 1'b0) $display("FAIL reset_rise got=%0b exp=0", bus.o_rise); else n_pass++;
        n_checks++; if (bus.o_fall !== 1'b0) $display("FAIL reset_fall got=%0b exp=0", bus.o_fall); else n_pass++;
        n_checks++; if (bus.o_period !== '0) $display("FAIL reset_period got=%0d exp=0", bus.o_period); else n_pass++;
        n_checks++; if (bus.o_period_valid !== 1'b0) $display("FAIL reset_valid got=%0b exp=0", bus.o_period_valid); else n_pass++;
        n_checks++; if (bus.o_locked !== 1'b0) $display("FAIL reset_locked got=%0b exp=0", bus.o_locked); else n_pass++;
        n_checks++; if (bus.o_timeout !== 1'b0) $display("FAIL reset_timeout got=%0b exp=0", bus.o_timeout); else n_pass++;
        i_rst = 1'b0;
    endtask

    task automatic test_lock;
        set_slow(1'b1, 1'b1, 1'b0, 1'b0);
        for (int k = 1; k <= 4; k++) period(1041, 1041, 1'b1, k == 4);
    endtask

    task automatic test_tolerance;
        hold(LAT);
        n_checks++; if (bus.o_locked !== 1'b1) $display("FAIL lock_after_5 got=%0b exp=1", bus.o_locked); else n_pass++;
        n_checks++; if (bus.o_period !== 13'd2082) $display("FAIL period_2082 got=%0d exp=2082", bus.o_period); else n_pass++;
        period(1042 - LAT, 1042, 1'b1, 1'b1);
        hold(LAT);
        n_checks++; if (bus.o_period !== 13'd2084 || bus.o_locked !== 1'b1) $display("FAIL tol_2084 period=%0d locked=%0b exp=2084/1", bus.o_period, bus.o_locked); else n_pass++;
        period(1042 - LAT, 1043, 1'b1, 1'b0);
        hold(LAT);
        n_checks++; if (bus.o_period !== 13'd2085 || bus.o_locked !== 1'b0) $display("FAIL tol_2085 period=%0d locked=%0b exp=2085/0", bus.o_period, bus.o_locked); else n_pass++;
        for (int k = 1; k <= 4; k++) period((k == 1) ? 1041 - LAT : 1041, 1041, 1'b1, k == 4);
    endtask

    task automatic test_timeout;
        int waited;
        int t0;
        t0 = last_rise;
        hold(1040);
        set_slow(1'b0, 1'b1, 1'b0, 1'b0);
        waited = 0;
        while (bus.o_timeout !== 1'b1 && waited < 6000) begin
            @(negedge clk);
            waited++;
        end
        n_checks++; if (bus.o_timeout !== 1'b1) $display("FAIL timeout_seen got=%0b exp=1", bus.o_timeout); else n_pass++;
        n_checks++; if (cyc !== t0 + LAT + TIMEOUT) $display("FAIL timeout_cycle got=%0d exp=%0d", cyc, t0 + LAT + TIMEOUT); else n_pass++;
        n_checks++; if (bus.o_locked !== 1'b0) $display("FAIL timeout_unlock got=%0b exp=0", bus.o_locked); else n_pass++;
        n_checks++; if (bus.o_period !== 13'd2082) $display("FAIL timeout_period_hold got=%0d exp=2082", bus.o_period); else n_pass++;
        set_slow(1'b1, 1'b1, 1'b0, 1'b0);
        hold(LAT);
        n_checks++; if (bus.o_timeout !== 1'b0) $display("FAIL timeout_clear got=%0b exp=0", bus.o_timeout); else n_pass++;
        for (int k = 1; k <= 4; k++) period((k == 1) ? 1041 - LAT : 1041, 1041, 1'b1, k == 4);
    endtask

    task automatic test_mid_reset;
        hold(1040);
        set_slow(1'b0, 1'b1, 1'b0, 1'b0);
        hold(499);
        @(negedge clk);
        i_rst = 1'b1;
        @(negedge clk);
        i_rst = 1'b0;
        n_checks++; if (bus.o_locked !== 1'b0 || bus.o_period !== '0 || bus.o_timeout !== 1'b0) $display("FAIL midreset_outputs locked=%0b period=%0d timeout=%0b exp=0/0/0", bus.o_locked, bus.o_period, bus.o_timeout); else n_pass++;
        n_checks++; if (bus.o_rise !== 1'b0 || bus.o_fall !== 1'b0 || bus.o_period_valid !== 1'b0) $display("FAIL midreset_strobes rise=%0b fall=%0b valid=%0b exp=0/0/0", bus.o_rise, bus.o_fall, bus.o_period_valid); else n_pass++;
        hold(538);
        set_slow(1'b1, 1'b1, 1'b0, 1'b0);
        for (int k = 1; k <= 4; k++) period(1041, 1041, 1'b1, k == 4);
    endtask

    task automatic test_enable;
        hold(1040);
        set_slow(1'b0, 1'b1, 1'b0, 1'b0);
        hold(499);
        @(negedge clk);
        bus.i_enable = 1'b0;
        @(negedge clk);
        n_checks++; if (bus.o_locked !== 1'b0 || bus.o_period !== '0 || bus.o_timeout !== 1'b0) $display("FAIL disable_clears locked=%0b period=%0d timeout=%0b exp=0/0/0", bus.o_locked, bus.o_period, bus.o_timeout); else n_pass++;
        hold(538);
        set_slow(1'b1, 1'b0, 1'b0, 1'b0);
        hold(1040);
        set_slow(1'b0, 1'b0, 1'b0, 1'b0);
        hold(1040);
        set_slow(1'b1, 1'b0, 1'b0, 1'b0);
        hold(376);
        @(negedge clk);
        bus.i_enable = 1'b1;
        hold(600);
        n_checks++; if (bus.o_locked !== 1'b0) $display("FAIL reenable_unlocked got=%0b exp=0", bus.o_locked); else n_pass++;
        set_slow(1'b0, 1'b1, 1'b0, 1'b0);
        hold(1040);
        set_slow(1'b1, 1'b1, 1'b0, 1'b0);
        for (int k = 1; k <= 4; k++) period(1041, 1041, 1'b1, k == 4);
    endtask

    task automatic test_glitch;
        hold(1040);
        set_slow(1'b0, 1'b1, 1'b0, 1'b0);
        hold(499);
`ifdef CLK_EDGE_MONITOR_GLITCH_FILTER_EN
        set_slow(1'b1, 1'b0, 1'b0, 1'b0);
        hold(1);
        set_slow(1'b0, 1'b0, 1'b0, 1'b0);
        hold(538);
        set_slow(1'b1, 1'b1, 1'b1, 1'b1);
        hold(LAT);
        n_checks++; if (bus.o_locked !== 1'b1 || bus.o_period !== 13'd2082) $display("FAIL glitch_filtered locked=%0b period=%0d exp=1/2082", bus.o_locked, bus.o_period); else n_pass++;
`else
        set_slow(1'b1, 1'b1, 1'b1, 1'b0);
        hold(1);
        set_slow(1'b0, 1'b1, 1'b0, 1'b0);
        hold(538);
        set_slow(1'b1, 1'b1, 1'b1, 1'b0);
        hold(LAT);
        n_checks++; if (bus.o_locked !== 1'b0 || bus.o_period !== 13'd541) $display("FAIL glitch_unfiltered locked=%0b period=%0d exp=0/541", bus.o_locked, bus.o_period); else n_pass++;
`endif
    endtask

    initial begin
        test_reset;
        test_lock;
        test_tolerance;
        test_timeout;
        test_mid_reset;
        test_enable;
        test_glitch;
        hold(LAT + 2);
        n_checks++; if (sb.size() != 0) $display("FAIL scoreboard_drain got=%0d exp=0", sb.size()); else n_pass++;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #999000;
        $display("FAIL watchdog cyc=%0d exp_finish_before=99900", cyc);
        $fatal(1, "watchdog expired");
    end
endmodule

// File: doc/clk_edge_monitor.md
Name: clk_edge_monitor

Overview:
- Receive-side counterpart of the divided slow clock: samples a slow clock (e.g. 48 kHz audio frame clock) in the fast system clock domain.
- Produces single-cycle rise/fall strobes and measures the full period in system clock cycles.
- Declares lock when the period matches the expected value, and flags loss of clock.
- Sits between any divided or external slow clock and logic that must act on its edges without using it as a clock.

Parameters:
- F_CLK_IN, 50_000_000, system clock frequency in Hz.
- F_CLK_OUT, 48_000, expected slow clock frequency in Hz.
- SYNC_STAGES, 2, synchronizer flop count, minimum 2.
- LOCK_COUNT, 4, consecutive in-tolerance periods required for lock, minimum 1.
- TOL, 2, allowed period deviation in system clock cycles, plus or minus.
- Derived: EXP = 2*(F_CLK_IN/F_CLK_OUT) = 2082; TIMEOUT = 2*EXP = 4164; NBITS = $clog2(TIMEOUT+1) = 13.

Ports:
- clk  in  1  system clock.
- i_rst  in  1  reset, synchronous, active-high.
- i_enable  in  1  monitor enable; low clears the monitor.
- i_clk_slow  in  1  asynchronous slow clock to monitor.
- o_rise  out  1  one-cycle pulse per synchronized rising edge.
- o_fall  out  1  one-cycle pulse per synchronized falling edge.
- o_period  out  NBITS  last measured rise-to-rise period in clk cycles.
- o_period_valid  out  1  one-cycle pulse when o_period updates.
- o_locked  out  1  level, period stable within tolerance.
- o_timeout  out  1  level, no rising edge for TIMEOUT cycles.

Behaviour:
- One clock domain: clk. Reset is synchronous, active-high, on i_rst.
- Reset values: all outputs 0; counter 0; state IDLE; sync chain 0.
- Synchronizer: i_clk_slow passes through SYNC_STAGES flops, then one history flop s_prev.
- Edge detect: rise = s & ~s_prev; fall = ~s & s_prev.
- Latency: o_rise/o_fall assert SYNC_STAGES+1 clk cycles after the input transition.
- Period counter:
  - Increments every cycle while enabled.
  - Saturates at TIMEOUT.
  - Cleared to 0 on each rise.
  - Measured period = counter+1 at the rise.
- States:
  - IDLE: no rise seen yet. On rise -> MEASURE. No period is reported.
  - MEASURE: one rise seen. On the next rise, load o_period, pulse o_period_valid, and check tolerance (|period-EXP| <= TOL).
    - In tolerance: good-count increments; when it reaches LOCK_COUNT -> LOCKED and set o_locked.
    - Out of tolerance: good-count returns to 0; stay in MEASURE.
  - LOCKED: every rise updates o_period and pulses valid.
    - Out-of-tolerance period -> MEASURE; clear o_locked and good-count in the same cycle o_period_valid pulses.
  - Any state, counter reaches TIMEOUT: set o_timeout, clear o_locked and good-count, go to IDLE.
- o_timeout clears on the next rise.
- A rise in the same cycle the counter reaches TIMEOUT takes priority: the period is processed normally and no timeout is raised.
- o_period holds its value between updates and through a timeout.
- i_enable low:
  - State, counter, good-count and all outputs are cleared as at reset.
  - The sync chain and s_prev keep sampling, so re-enabling causes no spurious edge.
- Reset mid-operation: takes effect on the next clk edge regardless of state; the first period after reset is never reported.
- Widths: comparisons are done in NBITS unsigned arithmetic; EXP+TOL must be <= TIMEOUT (checked at elaboration).

Optional Feature:
- Macro: CLK_EDGE_MONITOR_GLITCH_FILTER_EN.
- Defined:
  - A 3-cycle stability filter follows the synchronizer; s changes only after 3 consecutive identical synchronized samples.
  - Edge latency becomes SYNC_STAGES+3 cycles.
  - Pulses of 1 or 2 clk cycles on i_clk_slow are ignored.
- Undefined: no filter; s is the last sync stage directly.

Test Plan:
- Reset, then square wave with 2082-cycle period (1041 high / 1041 low) -> first rise gives no valid; valid pulses on rises 2..5 with o_period=2082; o_locked rises at rise 5; o_rise/o_fall appear 3 cycles after each transition.
- Locked, then one period of 2084 followed by one of 2085 -> 2084 keeps lock; at 2085 o_locked drops in the same cycle as valid with o_period=2085; relock after 4 more good periods.
- Locked, then hold i_clk_slow static -> o_timeout=1 and o_locked=0 exactly 4164 cycles after the last rise is counted; the next rise clears o_timeout and reports no period.
- Locked, then i_rst for 1 cycle mid-period -> all outputs 0 next cycle, o_period=0; relock requires 5 rises.
- i_enable low for 3000 cycles while the clock runs, then high -> no edges or valid while low; no spurious edge on re-enable; lock after 5 rises.
- With CLK_EDGE_MONITOR_GLITCH_FILTER_EN defined, inject a 2-cycle high glitch mid-low-phase while locked -> no o_rise/o_fall, o_period still 2082, lock held; with the macro undefined the same stimulus causes loss of lock.
